w_ingress: RTL and testbench
============================

# w_ingress

Write-domain ingress stage for the asynchronous FIFO. It sits directly upstream of the write-pointer controller. It accepts a valid/ready stream from the producer and buffers it in a 2-entry skid buffer, then drives the controller's winc and the RAM write data. It uses wfull to stall, and it keeps the producer's ready free of any combinational path from wfull. It also maintains per-domain statistics: accepted-word count and full-stall cycles.

## Interface
- DATASIZE, 8, width of data words.
- CNTW, 16, width of statistics counters.
- wclk  in  1  write-domain clock.
- wrst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  producer word valid.
- s_data  in  DATASIZE  producer word.
- s_ready  out  1  ingress can take a word this cycle.
- wfull  in  1  FIFO full, from the write-pointer controller.
- winc  out  1  write request to the controller.
- wdata  out  DATASIZE  word written to the FIFO RAM at the current write address.
- clr_stats  in  1  synchronous clear of both counters.
- wr_words  out  CNTW  words written into the FIFO, wrapping.
- stall_cycles  out  CNTW  cycles with winc=1 and wfull=1, saturating at all-ones.

## Operation
- **Handshake events:**
  - push = s_valid && s_ready.
  - pop = winc && !wfull.
  - Both events are evaluated at the rising edge of wclk.
- **State machine on occupancy:**
  - States: EMPTY (0 words), ONE (1), TWO (2).
  - EMPTY: push -> ONE; otherwise stay.
  - ONE: push && !pop -> TWO; pop && !push -> EMPTY; push && pop or neither -> ONE.
  - TWO: pop -> ONE. Push cannot occur in TWO.
- **Outputs:**
  - s_ready = (state != TWO), decoded from the state register only.
  - winc = (state != EMPTY).
  - wdata = head entry.
- **Storage:**
  - Two data registers, head and tail.
  - In ONE, push with simultaneous pop loads the new word into head.
  - In ONE, push without pop loads tail.
  - In TWO, pop moves tail into head.
  - Order is strictly FIFO. No word is dropped or duplicated.
- **Counters:**
  - wr_words increments by 1 on every pop and wraps modulo 2^CNTW.
  - stall_cycles increments on every cycle with winc && wfull and holds at 2^CNTW-1.
  - clr_stats zeroes both counters at the next edge. It has priority over a same-cycle increment, and that increment is lost.
- **Producer rule:** s_data and s_valid may change freely while s_ready=0. The ingress samples only on push.

## Timing
- **Reset values:**
  - state EMPTY.
  - s_ready=1, winc=0, wdata=0.
  - wr_words=0, stall_cycles=0.
  - Head and tail registers reset to 0.
- **Latency:**
  - A word pushed at edge N drives winc/wdata from just after edge N.
  - The earliest FIFO write of that word is at edge N+1, so input-to-FIFO latency is 1 cycle.
- **Throughput:** 1 word/cycle sustained while wfull=0, with no bubbles.
- **Back-pressure:**
  - When wfull rises, up to 2 words are absorbed.
  - s_ready falls at the edge that fills TWO.
  - s_ready rises at the edge of the first pop after wfull clears.
- **Path rule:** there is no combinational path wfull->s_ready or s_valid->winc. Every output is a function of registers, except wdata, which is a register mux.
- **wfull held indefinitely:** state stays TWO, winc stays 1, and stall_cycles saturates without wrap.
- **Reset mid-operation:**
  - Buffered words are discarded and outputs return to reset values asynchronously.
  - The write-pointer controller shares wrst_n, so no partial write is counted.

## Structure
- **Package w_ingress_pkg:**
  - State enum {EMPTY, ONE, TWO}.
  - Localparam for the counter saturation value.
- **Sub-module w_skid_buf:**
  - Natural split holding the state register, head/tail registers and the push/pop logic.
  - Parameterised by DATASIZE.
  - Exposes push and pop strobes to the top.
- **Top w_ingress:** instantiates w_skid_buf and holds both counters.

## Test plan
- **Idle-to-stream:** after reset, s_valid=1 with data 0x01..0x10 on consecutive cycles and wfull=0 -> winc high from cycle 1, wdata 0x01..0x10 in order, wr_words=16, s_ready never drops.
- **Full stall:** wfull=1 while streaming 0xA0, 0xA1, 0xA2 -> s_ready=0 after 0xA0 and 0xA1 are absorbed. Release wfull after 5 cycles -> writes 0xA0, 0xA1, 0xA2 in order, stall_cycles=5.
- **Simultaneous push/pop in ONE:** alternate s_valid with wfull toggling each cycle -> no loss or duplication; the scoreboard matches the input order exactly.
- **Saturation:** CNTW=4 and wfull=1 for 20 cycles with the buffer non-empty -> stall_cycles=15 and holds. wr_words wraps from 15 to 0 after 16 pops.
- **clr_stats:** assert in the same cycle as a pop with wr_words=7 -> wr_words=0 next cycle, and the next pop gives 1.
- **Reset mid-operation:** deassert wrst_n while in TWO holding 0x55/0x66 -> immediately state EMPTY, winc=0, s_ready=1, counters 0. After release, the new word 0x77 is the first written.

Source files
------------

// File: rtl/w_ingress_pkg.sv
// Shared types and constants for the write-domain ingress stage.
// The occupancy enum is used by the skid buffer; the saturation constant is sliced by the top.
package w_ingress_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  // Widest supported statistics counter; narrower counters take the low bits.
  localparam int CNT_MAX_W = 32;
  localparam logic [CNT_MAX_W-1:0] CNT_SAT_ALL = '1;

endpackage

// File: rtl/w_skid_buf.sv
// Two-entry skid buffer between the producer stream and the write-pointer controller.
// s_ready and winc are registered, so wfull has no combinational path to s_ready.
module w_skid_buf
  import w_ingress_pkg::*;
#(
  parameter int DATASIZE = 8
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                s_valid,
  input  logic [DATASIZE-1:0] s_data,
  output logic                s_ready,
  input  logic                wfull,
  output logic                winc,
  output logic [DATASIZE-1:0] wdata,
  output logic                push,
  output logic                pop
);

  occ_t                state_reg;
  logic [DATASIZE-1:0] head_reg;
  logic [DATASIZE-1:0] tail_reg;
  logic                ready_reg;
  logic                winc_reg;

  assign push    = s_valid && ready_reg;
  assign pop     = winc_reg && !wfull;
  assign s_ready = ready_reg;
  assign winc    = winc_reg;
  assign wdata   = head_reg;

  // ready_reg mirrors (state != TWO) and winc_reg mirrors (state != EMPTY).
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      tail_reg  <= '0;
      ready_reg <= 1'b1;
      winc_reg  <= 1'b0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (push) begin
            head_reg  <= s_data;
            state_reg <= ONE;
            winc_reg  <= 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            tail_reg  <= s_data;
            state_reg <= TWO;
            ready_reg <= 1'b0;
          end else if (push && pop) begin
            head_reg <= s_data;
          end else if (pop) begin
            state_reg <= EMPTY;
            winc_reg  <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            head_reg  <= tail_reg;
            state_reg <= ONE;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= EMPTY;
          ready_reg <= 1'b1;
          winc_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/w_ingress.sv
// Write-domain ingress: skid buffer feeding the write-pointer controller,
// plus wrapping accepted-word and saturating full-stall statistics.
module w_ingress
  import w_ingress_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int CNTW     = 16
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                s_valid,
  input  logic [DATASIZE-1:0] s_data,
  output logic                s_ready,
  input  logic                wfull,
  output logic                winc,
  output logic [DATASIZE-1:0] wdata,
  input  logic                clr_stats,
  output logic [CNTW-1:0]     wr_words,
  output logic [CNTW-1:0]     stall_cycles
);

  localparam logic [CNTW-1:0] STALL_SAT = CNT_SAT_ALL[CNTW-1:0];

  logic            push;
  logic            pop;
  logic [CNTW-1:0] words_reg;
  logic [CNTW-1:0] stall_reg;

  w_skid_buf #(
    .DATASIZE(DATASIZE)
  ) u_skid (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .s_valid(s_valid),
    .s_data (s_data),
    .s_ready(s_ready),
    .wfull  (wfull),
    .winc   (winc),
    .wdata  (wdata),
    .push   (push),
    .pop    (pop)
  );

  // A clear wins over a same-cycle increment; that increment is dropped.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      words_reg <= '0;
      stall_reg <= '0;
    end else if (clr_stats) begin
      words_reg <= '0;
      stall_reg <= '0;
    end else begin
      if (pop) begin
        words_reg <= words_reg + 1'b1;
      end
      if (winc && wfull && (stall_reg != STALL_SAT)) begin
        stall_reg <= stall_reg + 1'b1;
      end
    end
  end

  assign wr_words     = words_reg;
  assign stall_cycles = stall_reg;

  // A word accepted into an empty buffer is offered to the controller on the next cycle.
  a_push_to_winc: assert property (@(posedge wclk) disable iff (!wrst_n)
    (push && !winc) |=> winc);

endmodule

// File: tb/tb_w_ingress.sv
// Directed bench for w_ingress: stimulus records accepted words in a queue,
// a negedge monitor pops and compares every FIFO write.
module tb_w_ingress;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       wfull;
  logic       winc;
  logic [7:0] wdata;
  logic       clr_stats;
  logic [3:0] wr_words;
  logic [3:0] stall_cycles;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  w_ingress #(
    .DATASIZE(8),
    .CNTW    (4)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .wfull       (wfull),
    .winc        (winc),
    .wdata       (wdata),
    .clr_stats   (clr_stats),
    .wr_words    (wr_words),
    .stall_cycles(stall_cycles)
  );

  always #5 wclk = ~wclk;

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Monitor: pop-compare first (word already buffered), then record this cycle's push.
  always @(negedge wclk) begin
    logic [7:0] exp_word;
    if (!wrst_n) begin
      exp_q.delete();
    end else begin
      if (winc && !wfull) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL write_order actual=%0h required=none", wdata);
        end else begin
          exp_word = exp_q.pop_front();
          if (wdata !== exp_word) begin
            failures++;
            $display("FAIL write_order actual=%0h required=%0h", wdata, exp_word);
          end else begin
            $display("ok   write_order value=%0h", wdata);
          end
        end
      end
      if (s_valid && s_ready) exp_q.push_back(s_data);
    end
  end

  initial begin
    wrst_n    = 1'b0;
    s_valid   = 1'b0;
    s_data    = 8'h00;
    wfull     = 1'b0;
    clr_stats = 1'b0;
    repeat (3) step();
    check("reset_s_ready", 32'(s_ready), 32'd1);
    check("reset_winc", 32'(winc), 32'd0);
    check("reset_wdata", 32'(wdata), 32'd0);
    check("reset_wr_words", 32'(wr_words), 32'd0);
    check("reset_stall", 32'(stall_cycles), 32'd0);
    wrst_n = 1'b1;
    step();

    // Idle-to-stream: 0x01..0x10 back to back, no bubbles.
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      step();
      check("stream_s_ready", 32'(s_ready), 32'd1);
      if (i == 1) check("stream_winc_first", 32'(winc), 32'd1);
    end
    check("stream_wr_words_15", 32'(wr_words), 32'd15);
    s_valid = 1'b0;
    step();
    check("stream_wr_words_wrap", 32'(wr_words), 32'd0);
    check("stream_winc_idle", 32'(winc), 32'd0);

    // Full stall: two words absorbed, third held off for 5 stall cycles.
    wfull   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hA0;
    step();
    s_data = 8'hA1;
    step();
    check("stall_ready_low", 32'(s_ready), 32'd0);
    s_data = 8'hA2;
    repeat (4) step();
    check("stall_ready_held", 32'(s_ready), 32'd0);
    check("stall_cycles_5", 32'(stall_cycles), 32'd5);
    wfull = 1'b0;
    step();
    check("stall_ready_rise", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
    step();
    check("stall_wr_words", 32'(wr_words), 32'd3);
    check("stall_cycles_hold", 32'(stall_cycles), 32'd5);

    // Alternating push with wfull toggling: push+pop in ONE.
    for (int i = 0; i < 12; i++) begin
      s_valid = (i % 2 == 0);
      s_data  = 8'(8'h30 + i);
      wfull   = (i % 2 == 1);
      step();
    end
    s_valid = 1'b0;
    wfull   = 1'b0;
    repeat (2) step();
    check("alt_wr_words", 32'(wr_words), 32'd9);
    check("alt_stall", 32'(stall_cycles), 32'd11);

    // clr_stats: clear, then 7 pops, then clear coincident with a pop.
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    check("clr_idle_words", 32'(wr_words), 32'd0);
    check("clr_idle_stall", 32'(stall_cycles), 32'd0);
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h40 + i);
      step();
    end
    check("clr_pre_words", 32'(wr_words), 32'd7);
    s_valid   = 1'b0;
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    check("clr_with_pop", 32'(wr_words), 32'd0);
    s_valid = 1'b1;
    s_data  = 8'h48;
    step();
    s_valid = 1'b0;
    step();
    check("clr_next_pop", 32'(wr_words), 32'd1);

    // Saturation: wfull held with one word buffered.
    wfull   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h50;
    step();
    s_valid = 1'b0;
    repeat (14) step();
    check("sat_14", 32'(stall_cycles), 32'd14);
    repeat (6) step();
    check("sat_hold", 32'(stall_cycles), 32'd15);
    check("sat_winc", 32'(winc), 32'd1);
    wfull = 1'b0;
    step();
    check("sat_wr_words", 32'(wr_words), 32'd2);
    check("sat_after_release", 32'(stall_cycles), 32'd15);

    // Reset mid-operation while holding 0x55/0x66.
    wfull   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h55;
    step();
    s_data = 8'h66;
    step();
    s_valid = 1'b0;
    check("pre_reset_ready", 32'(s_ready), 32'd0);
    #1 wrst_n = 1'b0;
    #1;
    check("midrst_winc", 32'(winc), 32'd0);
    check("midrst_ready", 32'(s_ready), 32'd1);
    check("midrst_wdata", 32'(wdata), 32'd0);
    check("midrst_words", 32'(wr_words), 32'd0);
    check("midrst_stall", 32'(stall_cycles), 32'd0);
    repeat (2) step();
    wrst_n = 1'b1;
    wfull  = 1'b0;
    step();
    s_valid = 1'b1;
    s_data  = 8'h77;
    step();
    check("post_rst_wdata", 32'(wdata), 32'h77);
    s_valid = 1'b0;
    repeat (2) step();
    check("post_rst_words", 32'(wr_words), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
